// File: rtl/tile_map_renderer.sv
`default_nettype none
//------------------------------------------------------------------
// tile_map_renderer: tile board pixel pipeline with cursor overlay
// Revision: 1.0
//------------------------------------------------------------------
module tile_map_renderer #(
  parameter int          TILE_LOG2  = 5,
  parameter int          COLS       = 25,
  parameter int          ROWS       = 16,
  parameter int          V_OFFSET   = 88,
  parameter int          CODE_W     = 4,
  parameter logic [11:0] CURSOR_RGB = 12'hF00
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic [10:0]            h_coord,
  input  logic [9:0]             v_coord,
  input  logic                   wr_en,
  input  logic [7:0]             wr_col,
  input  logic [7:0]             wr_row,
  input  logic [CODE_W-1:0]      wr_code,
  input  logic                   button_u,
  input  logic                   button_d,
  input  logic                   button_l,
  input  logic                   button_r,
  input  logic [2:0]             SW,
  output logic [CODE_W-1:0]      tile_code,
  output logic [2*TILE_LOG2-1:0] tile_addr,
  input  logic [11:0]            tile_data,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic [7:0]             cursor_col,
  output logic [7:0]             cursor_row
);

  localparam int          IDX_W   = $clog2(COLS * ROWS);
  localparam logic [10:0] H_END   = 11'(COLS << TILE_LOG2);
  localparam logic [9:0]  V_START = 10'(V_OFFSET);
  localparam logic [9:0]  V_END   = 10'(V_OFFSET + (ROWS << TILE_LOG2));
  localparam logic [15:0] COLS_16 = 16'(COLS);
  localparam logic [7:0]  COL_MAX = 8'(COLS - 1);
  localparam logic [7:0]  ROW_MAX = 8'(ROWS - 1);

  logic [CODE_W-1:0] board_mem [COLS*ROWS];

  // Stage 0: pixel decode
  logic [9:0]           v_rel;
  logic [15:0]          pix_col;
  logic [15:0]          pix_row;
  logic [TILE_LOG2-1:0] pix_x;
  logic [TILE_LOG2-1:0] pix_y;
  logic                 pix_active;
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic                 wr_ok;

  // Registered state
  logic [CODE_W-1:0]      code_q;
  logic [2*TILE_LOG2-1:0] addr_q, addr_d;
  logic                   active_q, active_d;
  logic                   cursor_hit_q, cursor_hit_d;
  logic [11:0]            rgb_q, rgb_d;
  logic                   eof_q, eof_d;
  logic [3:0]             btn_prev_q, btn_prev_d;
  logic [3:0]             pend_q, pend_d;
  logic [7:0]             cursor_col_q, cursor_col_d;
  logic [7:0]             cursor_row_q, cursor_row_d;

  logic [3:0]  btn_rise;
  logic [11:0] bg_rgb;

  always_comb begin
    v_rel      = v_coord - V_START;
    pix_col    = 16'(h_coord >> TILE_LOG2);
    pix_row    = 16'(v_rel >> TILE_LOG2);
    pix_x      = h_coord[TILE_LOG2-1:0];
    pix_y      = v_rel[TILE_LOG2-1:0];
    pix_active = (h_coord < H_END) && (v_coord >= V_START) && (v_coord < V_END);
    rd_idx     = pix_active ? IDX_W'(pix_row * COLS_16 + pix_col) : '0;
    wr_ok      = wr_en && (wr_col < 8'(COLS)) && (wr_row < 8'(ROWS));
    wr_idx     = IDX_W'(16'(wr_row) * COLS_16 + 16'(wr_col));
  end

  // Board RAM: no reset, so the read register stays RAM-inferable
  always_ff @(posedge pixel_clk) begin
    if (wr_ok) begin
      board_mem[wr_idx] <= wr_code;
    end
    code_q <= board_mem[rd_idx];
  end

  // Stage 1 inputs
  always_comb begin
    addr_d       = {pix_y, pix_x};
    active_d     = pix_active;
    cursor_hit_d = pix_active
                && (pix_col == {8'd0, cursor_col_q})
                && (pix_row == {8'd0, cursor_row_q})
                && ((pix_x == '0) || (pix_x == '1) || (pix_y == '0) || (pix_y == '1));
  end

  // Stage 2 colour select
  always_comb begin
    bg_rgb = {(SW[2] ? 4'h8 : 4'h0), (SW[1] ? 4'h8 : 4'h0), (SW[0] ? 4'h8 : 4'h0)};
    if (cursor_hit_q) begin
      rgb_d = CURSOR_RGB;
    end else if (active_q) begin
      rgb_d = tile_data;
    end else begin
      rgb_d = bg_rgb;
    end
  end

  // Button bit order: {u, d, l, r}
  always_comb begin
    eof_d      = (h_coord[9:0] == 10'd799) && (v_coord == 10'd599);
    btn_prev_d = {button_u, button_d, button_l, button_r};
    btn_rise   = btn_prev_d & ~btn_prev_q;
    pend_d     = eof_q ? btn_rise : (pend_q | btn_rise);

    cursor_col_d = cursor_col_q;
    cursor_row_d = cursor_row_q;
    if (eof_q) begin
      if (pend_q[1] && !pend_q[0] && (cursor_col_q != 8'd0)) begin
        cursor_col_d = cursor_col_q - 8'd1;
      end else if (pend_q[0] && !pend_q[1] && (cursor_col_q < COL_MAX)) begin
        cursor_col_d = cursor_col_q + 8'd1;
      end
      if (pend_q[3] && !pend_q[2] && (cursor_row_q != 8'd0)) begin
        cursor_row_d = cursor_row_q - 8'd1;
      end else if (pend_q[2] && !pend_q[3] && (cursor_row_q < ROW_MAX)) begin
        cursor_row_d = cursor_row_q + 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      active_q     <= 1'b0;
      cursor_hit_q <= 1'b0;
      rgb_q        <= '0;
      eof_q        <= 1'b0;
      btn_prev_q   <= '0;
      pend_q       <= '0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
    end else begin
      addr_q       <= addr_d;
      active_q     <= active_d;
      cursor_hit_q <= cursor_hit_d;
      rgb_q        <= rgb_d;
      eof_q        <= eof_d;
      btn_prev_q   <= btn_prev_d;
      pend_q       <= pend_d;
      cursor_col_q <= cursor_col_d;
      cursor_row_q <= cursor_row_d;
    end
  end

  assign tile_code  = code_q;
  assign tile_addr  = addr_q;
  assign red        = rgb_q[3:0];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[11:8];
  assign cursor_col = cursor_col_q;
  assign cursor_row = cursor_row_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_map_renderer.sv
`default_nettype none
//------------------------------------------------------------------
// tb_tile_map_renderer: directed self-checking bench
// Revision: 1.0
//------------------------------------------------------------------
module tb_tile_map_renderer;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        wr_en;
  logic [7:0]  wr_col;
  logic [7:0]  wr_row;
  logic [3:0]  wr_code;
  logic        button_u, button_d, button_l, button_r;
  logic [2:0]  SW;
  logic [3:0]  tile_code;
  logic [9:0]  tile_addr;
  logic [11:0] tile_data;
  logic [3:0]  red, green, blue;
  logic [7:0]  cursor_col, cursor_row;

  int n_pass  = 0;
  int n_total = 0;

  tile_map_renderer dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .h_coord   (h_coord),
    .v_coord   (v_coord),
    .wr_en     (wr_en),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_code   (wr_code),
    .button_u  (button_u),
    .button_d  (button_d),
    .button_l  (button_l),
    .button_r  (button_r),
    .SW        (SW),
    .tile_code (tile_code),
    .tile_addr (tile_addr),
    .tile_data (tile_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    button_u = u; button_d = d; button_l = l; button_r = r;
    tick();
    button_u = 0; button_d = 0; button_l = 0; button_r = 0;
    tick();
  endtask

  task automatic end_frame();
    h_coord = 11'd799; v_coord = 10'd599;
    tick();
    h_coord = 11'd850; v_coord = 10'd40;
    tick();
  endtask

  task automatic show(input logic [10:0] h, input logic [9:0] v);
    h_coord = h; v_coord = v;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 0; h_coord = 11'd0; v_coord = 10'd88;
    wr_en = 0; wr_col = 0; wr_row = 0; wr_code = 0;
    button_u = 0; button_d = 0; button_l = 0; button_r = 0;
    SW = 3'b000; tile_data = 12'hABC;

    repeat (3) tick();
    check("reset_rgb", {blue, green, red}, 12'h000);
    check("reset_cursor", {cursor_col, cursor_row}, 16'h0000);

    rst_n = 1;
    tick(); tick();
    check("cursor_corner", {blue, green, red}, 12'hF00);

    wr_en = 1; wr_col = 8'd3; wr_row = 8'd2; wr_code = 4'd5;
    tick();
    wr_en = 0;
    h_coord = 11'd103; v_coord = 10'd156;
    tick();
    check("tile_code_n1", tile_code, 4'd5);
    check("tile_addr_n1", tile_addr, 10'h087);
    check("rgb_not_yet_n1", {blue, green, red}, 12'hF00);
    tick();
    check("rgb_tile_n2", {blue, green, red}, 12'hABC);

    show(11'd5, 10'd93);
    check("cursor_interior", {blue, green, red}, 12'hABC);
    show(11'd31, 10'd100);
    check("cursor_right_edge", {blue, green, red}, 12'hF00);
    show(11'd32, 10'd88);
    check("next_cell_top", {blue, green, red}, 12'hABC);

    SW = 3'b101;
    show(11'd850, 10'd156);
    check("bg_h_out", {blue, green, red}, 12'h808);
    show(11'd100, 10'd40);
    check("bg_v_out", {blue, green, red}, 12'h808);
    SW = 3'b010;
    show(11'd100, 10'd600);
    check("bg_v_end", {blue, green, red}, 12'h080);
    show(11'd800, 10'd100);
    check("bg_h_end", {blue, green, red}, 12'h080);

    wr_en = 1; wr_col = 8'd0; wr_row = 8'd1; wr_code = 4'd3;
    tick();
    wr_col = 8'd25; wr_row = 8'd0; wr_code = 4'd9;
    tick();
    wr_en = 0;
    h_coord = 11'd0; v_coord = 10'd120;
    tick();
    check("oob_write_ignored", tile_code, 4'd3);

    wr_en = 1; wr_col = 8'd3; wr_row = 8'd2; wr_code = 4'd7;
    h_coord = 11'd103; v_coord = 10'd156;
    tick();
    wr_en = 0;
    check("same_cycle_old", tile_code, 4'd5);
    tick();
    check("next_read_new", tile_code, 4'd7);

    pulse(0, 0, 0, 1); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
    check("no_move_before_eof", {cursor_col, cursor_row}, 16'h0000);
    end_frame();
    check("three_pulses_one_step", {cursor_col, cursor_row}, {8'd1, 8'd0});
    pulse(0, 1, 0, 0); end_frame();
    check("move_down", {cursor_col, cursor_row}, {8'd1, 8'd1});
    pulse(1, 0, 0, 0); end_frame();
    check("move_up", {cursor_col, cursor_row}, {8'd1, 8'd0});
    pulse(0, 0, 1, 0); end_frame();
    check("move_left", {cursor_col, cursor_row}, {8'd0, 8'd0});
    pulse(1, 0, 1, 0); end_frame();
    check("saturate_low", {cursor_col, cursor_row}, {8'd0, 8'd0});

    for (int i = 0; i < 24; i++) begin
      pulse(0, (i < 15), 0, 1);
      end_frame();
    end
    check("reach_corner", {cursor_col, cursor_row}, {8'd24, 8'd15});
    pulse(0, 1, 0, 1); end_frame();
    check("saturate_high", {cursor_col, cursor_row}, {8'd24, 8'd15});
    pulse(0, 0, 1, 1); end_frame();
    check("l_and_r_cancel", {cursor_col, cursor_row}, {8'd24, 8'd15});
    pulse(1, 1, 0, 0); end_frame();
    check("u_and_d_cancel", {cursor_col, cursor_row}, {8'd24, 8'd15});

    h_coord = 11'd799; v_coord = 10'd599;
    tick();
    button_l = 1; h_coord = 11'd850; v_coord = 10'd40;
    tick();
    button_l = 0;
    check("edge_in_eof_not_applied", {cursor_col, cursor_row}, {8'd24, 8'd15});
    end_frame();
    check("edge_in_eof_deferred", {cursor_col, cursor_row}, {8'd23, 8'd15});

    SW = 3'b000;
    show(11'd103, 10'd156);
    check("pre_reset", {blue, green, red}, 12'hABC);
    rst_n = 0;
    tick();
    check("reset_mid_frame", {blue, green, red}, 12'h000);
    check("reset_cursor_mid", {cursor_col, cursor_row}, 16'h0000);
    rst_n = 1;
    tick();
    check("resume_not_yet", {blue, green, red}, 12'h000);
    check("board_kept", tile_code, 4'd7);
    tick();
    check("resume_two_cycles", {blue, green, red}, 12'hABC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
